// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : proc_pkg
// Purpose  : Shared pipeline definitions: memory opcodes, memory-stage state
//            encoding and the NOP instruction word.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package proc_pkg;

    localparam logic [4:0]  OP_LW  = 5'b01000;
    localparam logic [4:0]  OP_SW  = 5'b00111;
    localparam logic [31:0] NOP_IR = 32'h0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    function automatic logic [4:0] ir_opcode(input logic [31:0] ir);
        return ir[31:27];
    endfunction

endpackage : proc_pkg
`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : mem_timeout_ctr
// Purpose  : 8-bit cycle counter for an outstanding memory access. Clear has
//            priority over enable; tc flags count == TC_VAL.
// Ports    : clock, ctrl_reset (async, active-low), clear, enable -> tc
// Revision : 1.0 - initial release
// ============================================================================
module mem_timeout_ctr #(
    parameter logic [7:0] TC_VAL = 8'd15
) (
    input  logic clock,
    input  logic ctrl_reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (enable) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == TC_VAL);

endmodule : mem_timeout_ctr
`default_nettype wire

// File: rtl/register.sv
`default_nettype none
// ============================================================================
// Module   : register
// Purpose  : Generic pipeline register with load enable and async clear.
// Ports    : clock, ctrl_reset (async, active-low), input_enable, d -> q
// Revision : 1.0 - initial release
// ============================================================================
module register #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             input_enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            q <= '0;
        end else if (input_enable) begin
            q <= d;
        end
    end

endmodule : register
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Pipeline memory-access stage. Passes non-memory instructions
//            through in one cycle; runs lw/sw over a req/ack data port while
//            stalling X/M, abandoning an access after TIMEOUT cycles.
// Ports    : clock, ctrl_reset (async, active-low)
//            in_O/in_B/in_ir/in_valid  - from X/M register
//            stall                     - holds X/M register
//            dmem_req/we/addr/wdata    - registered memory request
//            dmem_ack/rdata            - memory response
//            out_O/out_D/out_ir/out_valid - to M/W register
//            mem_error                 - sticky timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
    import proc_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic [31:0]       in_O,
    input  logic [31:0]       in_B,
    input  logic [31:0]       in_ir,
    input  logic              in_valid,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic [31:0]       out_O,
    output logic [31:0]       out_D,
    output logic [31:0]       out_ir,
    output logic              out_valid,
    output logic              mem_error
);

    logic is_lw;
    logic is_sw;
    logic is_mem;

    assign is_lw  = (ir_opcode(in_ir) == OP_LW);
    assign is_sw  = (ir_opcode(in_ir) == OP_SW);
    assign is_mem = in_valid & (is_lw | is_sw);

    mem_state_t        state_q, state_d;
    logic              dmem_req_q, dmem_req_d;
    logic              dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [31:0]       dmem_wdata_q, dmem_wdata_d;
    logic [31:0]       cap_o_q, cap_o_d;
    logic [31:0]       cap_ir_q, cap_ir_d;
    logic              cap_lw_q, cap_lw_d;
    logic              mem_error_q, mem_error_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_o_d;
    logic [31:0]       out_d_d;
    logic [31:0]       out_ir_d;
    logic              tc;

    // Counter sits at zero throughout IDLE and advances on every ACCESS cycle
    // without an ack, so tc marks the TIMEOUT-th ACCESS cycle.
    mem_timeout_ctr #(
        .TC_VAL (8'(TIMEOUT - 1))
    ) u_timeout_ctr (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .clear      (state_q == IDLE),
        .enable     ((state_q == ACCESS) & ~dmem_ack),
        .tc         (tc)
    );

    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        cap_o_d      = cap_o_q;
        cap_ir_d     = cap_ir_q;
        cap_lw_d     = cap_lw_q;
        mem_error_d  = mem_error_q;
        out_valid_d  = 1'b0;
        out_o_d      = 32'h0;
        out_d_d      = 32'h0;
        out_ir_d     = NOP_IR;
        stall        = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_mem) begin
                    stall        = 1'b1;
                    state_d      = ACCESS;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = is_sw;
                    dmem_addr_d  = in_O[ADDR_W-1:0];
                    dmem_wdata_d = in_B;
                    cap_o_d      = in_O;
                    cap_ir_d     = in_ir;
                    cap_lw_d     = is_lw;
                end else begin
                    out_o_d     = in_O;
                    out_ir_d    = in_ir;
                    out_valid_d = in_valid;
                end
            end
            ACCESS: begin
                // Ack is checked before tc so an ack on the last allowed
                // cycle completes normally and leaves mem_error untouched.
                if (dmem_ack) begin
                    state_d     = IDLE;
                    dmem_req_d  = 1'b0;
                    dmem_we_d   = 1'b0;
                    out_o_d     = cap_o_q;
                    out_ir_d    = cap_ir_q;
                    out_d_d     = cap_lw_q ? dmem_rdata : 32'h0;
                    out_valid_d = 1'b1;
                end else if (tc) begin
                    state_d     = IDLE;
                    dmem_req_d  = 1'b0;
                    mem_error_d = 1'b1;
                    out_o_d     = cap_o_q;
                    out_ir_d    = cap_ir_q;
                    out_valid_d = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state_q      <= IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= 32'h0;
            cap_o_q      <= 32'h0;
            cap_ir_q     <= NOP_IR;
            cap_lw_q     <= 1'b0;
            mem_error_q  <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            cap_o_q      <= cap_o_d;
            cap_ir_q     <= cap_ir_d;
            cap_lw_q     <= cap_lw_d;
            mem_error_q  <= mem_error_d;
            out_valid_q  <= out_valid_d;
        end
    end

    register #(.WIDTH(32)) u_out_o (
        .clock (clock), .ctrl_reset (ctrl_reset), .input_enable (1'b1),
        .d (out_o_d), .q (out_O)
    );

    register #(.WIDTH(32)) u_out_d (
        .clock (clock), .ctrl_reset (ctrl_reset), .input_enable (1'b1),
        .d (out_d_d), .q (out_D)
    );

    register #(.WIDTH(32)) u_out_ir (
        .clock (clock), .ctrl_reset (ctrl_reset), .input_enable (1'b1),
        .d (out_ir_d), .q (out_ir)
    );

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign out_valid  = out_valid_q;
    assign mem_error  = mem_error_q;

endmodule : mem_stage
`default_nettype wire
